// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder that streams encoded instructions as sequential imem writes.
// One output register gives 1-cycle latency with full throughput under back-pressure.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] count,
  output logic        done,
  output logic        err
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [31:0] LastAddr = BASE_ADDR + 32'(4 * (DEPTH - 1));

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        last_pending_q, last_pending_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] enc_data;
  logic        enc_err;
  logic        fits12, fits13, fits21;
  logic        in_fire, wr_fire;

  // Immediate range checks: all bits above the field's sign bit must replicate it.
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    enc_data = 32'h0000_0013;
    enc_err  = 1'b0;
    case (opcode)
      OpR: enc_data = {funct7, rs2, rs1, funct3, rd, opcode};
      OpImm, OpLoad: begin
        enc_data = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !fits12;
      end
      OpStore: begin
        enc_data = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits12;
      end
      OpBranch: begin
        enc_data = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = imm[0] || !fits13;
      end
      OpJal: begin
        enc_data = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = imm[0] || !fits21;
      end
      OpLui, OpAuipc: enc_data = {imm[31:12], rd, opcode};
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready = (state_q == StRun) && !last_pending_q && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign wr_fire  = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    last_pending_d = last_pending_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    count_d        = count_q;
    err_d          = err_q;

    if (wr_fire) begin
      out_valid_d = 1'b0;
      wr_addr_d   = (wr_addr_q == LastAddr) ? BASE_ADDR : wr_addr_q + 32'd4;
      count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end
    // A new beat may load the register in the same cycle the previous word drains.
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      wr_data_d   = enc_data;
      err_d       = err_q | enc_err;
      if (in_last) last_pending_d = 1'b1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d        = StRun;
          wr_addr_d      = BASE_ADDR;
          count_d        = 16'd0;
          err_d          = 1'b0;
          last_pending_d = 1'b0;
        end
      end
      StRun: begin
        if (wr_fire && out_last_q) begin
          state_d        = StDone;
          last_pending_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      last_pending_q <= 1'b0;
      wr_addr_q      <= BASE_ADDR;
      wr_data_q      <= 32'd0;
      count_q        <= 16'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      last_pending_q <= last_pending_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      count_q        <= count_d;
      err_q          <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign count     = count_q;
  assign done      = (state_q == StDone);
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program loads plus randomized beats
// checked against an encoding model and an expected-write queue.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] count;
  logic        done, err;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int unsigned wcount;
  logic        exp_err;
  logic        chk_done;
  int          rdy_mode;
  int          errors = 0;
  int          checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding rules computed directly from the RV32I field layouts.
  function automatic void ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [31:0] im, output logic [31:0] w,
                                     output logic bad);
    int unsigned u, base;
    int s;
    u    = im;
    s    = signed'(im);
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    bad  = 1'b0;
    case (op)
      7'b0110011: w = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
      7'b0010011, 7'b0000011: begin
        w   = ((u & 32'hfff) << 20) | base | (32'(d) << 7);
        bad = (s < -2048) || (s > 2047);
      end
      7'b0100011: begin
        w   = (((u >> 5) & 32'h7f) << 25) | (32'(s2) << 20) | base | ((u & 32'h1f) << 7);
        bad = (s < -2048) || (s > 2047);
      end
      7'b1100011: begin
        w   = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(s2) << 20) | base
            | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7);
        bad = ((u & 1) != 0) || (s < -4096) || (s > 4095);
      end
      7'b1101111: begin
        w   = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 32'hff) << 12) | (32'(d) << 7) | 32'(op);
        bad = ((u & 1) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
      end
      7'b0110111, 7'b0010111: w = (u & 32'hffff_f000) | (32'(d) << 7) | 32'(op);
      default: begin
        w   = 32'h0000_0013;
        bad = 1'b1;
      end
    endcase
  endfunction

  // Write monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      chk_done = 1'b0;
    end else begin
      if (chk_done) begin
        check_eq("done_after_last", 32'(done), 32'd1);
        chk_done = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check_eq("spurious_write", 32'(out_valid & out_ready), 32'd0);
        end else begin
          mon_e = expq.pop_front();
          check_eq("wr_data", wr_data, mon_e.data);
          check_eq("wr_addr", wr_addr, BASE + 32'(4 * (wcount % DEPTH)));
          check_eq("count_at_write", 32'(count), 32'(wcount[15:0]));
          check_eq("done_before_last", 32'(done), 32'd0);
          if (mon_e.last) chk_done = 1'b1;
          wcount++;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wcount  = 0;
    exp_err = 1'b0;
    expq.delete();
    check_eq("start_done", 32'(done), 32'd0);
    check_eq("start_count", 32'(count), 32'd0);
    check_eq("start_addr", wr_addr, BASE);
    check_eq("start_err", 32'(err), 32'd0);
  endtask

  task automatic drive_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] im, input logic last);
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_last = last; in_valid = 1'b1;
  endtask

  task automatic wait_accept(input logic [31:0] exp_data, input logic bad);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.data = exp_data;
      e.last = in_last;
      expq.push_back(e);
      exp_err = exp_err | bad;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic last, input logic [31:0] exp_data,
                      input logic bad);
    drive_fields(op, f3, f7, d, s1, s2, im, last);
    wait_accept(exp_data, bad);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_reached", 32'(done), 32'd1);
    check_eq("queue_drained", 32'(expq.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm(input logic [6:0] op);
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    case (op)
      7'b1100011: begin
        v = int'($urandom_range(0, 4095)) - 2048;
        return 32'(v * 2);
      end
      7'b1101111: begin
        v = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
        return 32'(v * 2);
      end
      7'b0110111, 7'b0010111: return $urandom;
      default: begin
        v = int'($urandom_range(0, 4095)) - 2048;
        return 32'(v);
      end
    endcase
  endfunction

  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b0110111, 7'b0010111, 7'h7F};

  initial begin
    logic [6:0]  r_op, r_f7;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd, r_s1, r_s2;
    logic [31:0] r_imm, r_w;
    logic        r_bad;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    rdy_mode = 0; wcount = 0; exp_err = 1'b0; chk_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_wr_addr", wr_addr, BASE);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // addi x1,x0,5
    do_start();
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
    wait_done();
    check_eq("addi_count", 32'(count), 32'd1);
    check_eq("addi_err", 32'(err), 32'd0);

    // add x3,x1,x2 ; sw x2,8(x1)
    do_start();
    send(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3, 1'b0);
    send(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423, 1'b0);
    wait_done();
    check_eq("prog2_count", 32'(count), 32'd2);

    // beq / jal / lui
    do_start();
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_8463, 1'b0);
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 32'h0100_00EF, 1'b0);
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7, 1'b0);
    wait_done();
    check_eq("bju_err", 32'(err), 32'd0);

    // Back-pressure: word held stable, next beat stalled.
    do_start();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0);
    drive_fields(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_wr_data", wr_data, 32'h0050_0093);
      check_eq("hold_wr_addr", wr_addr, BASE);
    end
    rdy_mode = 0;
    wait_accept(32'h1234_52B7, 1'b0);
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h0100_00EF, 1'b0);
    wait_done();
    check_eq("hold_count", 32'(count), 32'd3);

    // Unknown opcode then misaligned branch.
    do_start();
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0000_0013, 1'b1);
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd9, 1'b1, 32'h0020_8463, 1'b1);
    wait_done();
    check_eq("err_sticky", 32'(err), 32'(exp_err));

    // Address wrap with DEPTH words.
    do_start();
    for (int i = 0; i < 5; i++)
      send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'(i == 4), 32'h0050_0093, 1'b0);
    wait_done();
    check_eq("wrap_count", 32'(count), 32'd5);
    check_eq("wrap_addr", wr_addr, BASE + 32'd4);

    // Reset while a word is pending.
    do_start();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_addr", wr_addr, BASE);
    check_eq("mid_rst_data", wr_data, 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    expq.delete();
    wcount = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized program against the encoding model.
    do_start();
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r_op  = ops[$urandom_range(0, 8)];
      r_f3  = 3'($urandom);
      r_f7  = 7'($urandom);
      r_rd  = 5'($urandom);
      r_s1  = 5'($urandom);
      r_s2  = 5'($urandom);
      r_imm = rand_imm(r_op);
      ref_encode(r_op, r_f3, r_f7, r_rd, r_s1, r_s2, r_imm, r_w, r_bad);
      send(r_op, r_f3, r_f7, r_rd, r_s1, r_s2, r_imm, 1'(i == 39), r_w, r_bad);
    end
    wait_done();
    check_eq("rand_count", 32'(count), 32'd40);
    check_eq("rand_err", 32'(err), 32'(exp_err));
    check_eq("rand_addr", wr_addr, BASE + 32'(4 * (40 % DEPTH)));

    do_start();
    check_eq("restart_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
